// File: rtl/i2s_clk_ctrl.sv
// I2S bus-master timing controller: derives SCK/WS from the main clock with
// Wishbone-programmable divider and word length, frame counter and interrupt.
module i2s_clk_ctrl #(
  parameter logic [7:0] DIV_RST  = 8'd1,
  parameter logic [4:0] WLEN_RST = 5'd15
) (
  input  logic        i2s_clk_i,
  input  logic        i2s_rst_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  input  logic [31:0] wbs_addr_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic        i2s_sck_o,
  output logic        i2s_ws_o,
  output logic        frame_start_o,
  output logic        irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]  state;
  logic        en;
  logic        irq_en;
  logic        irq;
  logic [7:0]  div;
  logic [4:0]  wlen;
  logic [31:0] frame_cnt;
  logic [7:0]  div_sh;
  logic [4:0]  wlen_sh;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;

  logic        access;
  logic        wr;
  logic [1:0]  addr;
  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_fcnt;
  logic [4:0]  wlen_wr;
  logic [7:0]  div_next;
  logic [4:0]  wlen_next;
  logic        active;
  logic        tick;
  logic        fall;
  logic        boundary;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign access    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr        = access & wbs_we_i;
  assign addr      = wbs_addr_i[3:2];
  assign wr_ctrl   = wr && (addr == 2'd0);
  assign wr_status = wr && (addr == 2'd1);
  assign wr_fcnt   = wr && (addr == 2'd2);

  // Word lengths below 8 bits are not useful on the bus, so they are clamped.
  assign wlen_wr   = (wbs_data_i[20:16] < 5'd7) ? 5'd7 : wbs_data_i[20:16];
  assign div_next  = wr_ctrl ? wbs_data_i[15:8] : div;
  assign wlen_next = wr_ctrl ? wlen_wr : wlen;

  assign active   = (state != ST_IDLE);
  assign tick     = active && (div_cnt == div_sh);
  assign fall     = tick && i2s_sck_o;
  assign boundary = fall && (bit_cnt == wlen_sh) && i2s_ws_o;

  assign irq_o     = irq & irq_en;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;

  assign unused_bits = ^{wbs_sel_i, wbs_addr_i[31:4], wbs_addr_i[1:0],
                         wbs_data_i[31:21], wbs_data_i[7:2]};

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      2'd0: rd_mux = {11'd0, wlen, div, 6'd0, irq_en, en};
      2'd1: rd_mux = {30'd0, irq, active};
      2'd2: rd_mux = frame_cnt;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
    if (i2s_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_data_o <= 32'd0;
    end else begin
      wbs_ack_o  <= access;
      wbs_data_o <= access ? rd_mux : 32'd0;
    end
  end

  // Frame boundary events take priority over coincident clears.
  always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
    if (i2s_rst_i) begin
      en        <= 1'b0;
      irq_en    <= 1'b0;
      div       <= DIV_RST;
      wlen      <= WLEN_RST;
      irq       <= 1'b0;
      frame_cnt <= 32'd0;
    end else begin
      if (wr_ctrl) begin
        en     <= wbs_data_i[0];
        irq_en <= wbs_data_i[1];
        div    <= wbs_data_i[15:8];
        wlen   <= wlen_wr;
      end
      if (boundary)
        irq <= 1'b1;
      else if (wr_status && wbs_data_i[1])
        irq <= 1'b0;
      if (wr_fcnt)
        frame_cnt <= boundary ? 32'd1 : 32'd0;
      else if (boundary)
        frame_cnt <= frame_cnt + 32'd1;
    end
  end

  always_ff @(posedge i2s_clk_i or posedge i2s_rst_i) begin
    if (i2s_rst_i) begin
      state         <= ST_IDLE;
      div_sh        <= DIV_RST;
      wlen_sh       <= WLEN_RST;
      div_cnt       <= 8'd0;
      bit_cnt       <= 5'd0;
      i2s_sck_o     <= 1'b0;
      i2s_ws_o      <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      frame_start_o <= boundary;
      case (state)
        ST_IDLE: begin
          div_cnt   <= 8'd0;
          bit_cnt   <= 5'd0;
          i2s_sck_o <= 1'b0;
          i2s_ws_o  <= 1'b0;
          if (en) begin
            state   <= ST_RUN;
            div_sh  <= div_next;
            wlen_sh <= wlen_next;
          end
        end
        ST_RUN, ST_STOP: begin
          if (tick) begin
            div_cnt   <= 8'd0;
            i2s_sck_o <= ~i2s_sck_o;
            if (fall) begin
              if (bit_cnt == wlen_sh) begin
                bit_cnt  <= 5'd0;
                i2s_ws_o <= ~i2s_ws_o;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
          // A stop request only lands on a frame boundary, where sck/ws are already low.
          if (boundary) begin
            div_sh  <= div_next;
            wlen_sh <= wlen_next;
            state   <= en ? ST_RUN : ST_IDLE;
          end else begin
            state <= en ? ST_RUN : ST_STOP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Directed self-checking bench for i2s_clk_ctrl: register defaults, SCK/WS
// timing, graceful stop, shadowing, WLEN clamp and interrupt/counter races.
module tb_i2s_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic [31:0] wb_addr;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_rty;
  logic        sck;
  logic        ws;
  logic        frame_start;
  logic        irq;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int t          = 0;
  int fs_count   = 0;
  int fs_last    = 0;
  int fs_prev    = 0;
  int falls      = 0;
  int ws_rise_falls = -1;
  int irq_rise_t = -1;
  logic prev_sck = 1'b0;
  logic prev_ws  = 1'b0;
  logic prev_irq = 1'b0;

  i2s_clk_ctrl dut (
    .i2s_clk_i     (clk),
    .i2s_rst_i     (rst),
    .wbs_data_i    (wb_wdata),
    .wbs_data_o    (wb_rdata),
    .wbs_addr_i    (wb_addr),
    .wbs_sel_i     (wb_sel),
    .wbs_we_i      (wb_we),
    .wbs_cyc_i     (wb_cyc),
    .wbs_stb_i     (wb_stb),
    .wbs_ack_o     (wb_ack),
    .wbs_err_o     (wb_err),
    .wbs_rty_o     (wb_rty),
    .i2s_sck_o     (sck),
    .i2s_ws_o      (ws),
    .frame_start_o (frame_start),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  // Event recorder sampled 1 ns after each rising edge; t counts clocks.
  always begin
    @(posedge clk);
    #1;
    t++;
    if (frame_start) begin
      fs_count++;
      fs_prev = fs_last;
      fs_last = t;
    end
    if (prev_sck && !sck) falls++;
    if (ws && !prev_ws && ws_rise_falls < 0) ws_rise_falls = falls;
    if (irq && !prev_irq) irq_rise_t = t;
    prev_sck = sck;
    prev_ws  = ws;
    prev_irq = irq;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic [31:0] addr, input logic [31:0] data,
                           input logic we, output logic [31:0] rdata);
    int n;
    wb_addr  = addr;
    wb_wdata = data;
    wb_we    = we;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack && n < 8);
    if (!wb_ack) check_output("wb_ack_timeout", {31'd0, wb_ack}, 32'd1);
    rdata  = wb_rdata;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_access(addr, data, 1'b1, dummy);
  endtask

  task automatic wb_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(addr, 32'd0, 1'b0, d);
    check_output(tag, d, exp);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (fs_count < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (fs_count < target) check_output("frame_timeout", 32'(fs_count), 32'(target));
  endtask

  // Clocks from now until the next observed SCK rising edge.
  task automatic measure_rise(output int n);
    n = 0;
    while (sck && n < 500) begin
      @(negedge clk);
      n++;
    end
    while (!sck && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    wb_wdata = 32'd0;
    wb_addr  = 32'd0;
    wb_sel   = 4'hF;
    wb_we    = 1'b0;
    wb_cyc   = 1'b0;
    wb_stb   = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", {26'd0, sck, ws, frame_start, irq, wb_ack, wb_err | wb_rty}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    wb_check("ctrl_default", 32'h0, 32'h000F0100);
    wb_check("status_default", 32'h4, 32'h0);
    wb_check("fcnt_default", 32'h8, 32'h0);
    wb_check("reg_c_reads_zero", 32'hC, 32'h0);

    // Basic timing with DIV=1, WLEN=15: one clock to leave IDLE, then DIV+1.
    falls = 0;
    ws_rise_falls = -1;
    wb_write(32'h0, 32'h000F0101);
    measure_rise(n);
    check_output("first_sck_rise", 32'(n), 32'd3);
    measure_rise(n);
    check_output("sck_period", 32'(n), 32'd4);
    wait_frames(1);
    check_output("ws_rise_after_16_falls", 32'(ws_rise_falls), 32'd16);
    wait_frames(3);
    check_output("frame_period_128", 32'(fs_last - fs_prev), 32'd128);
    wb_check("fcnt_after_3", 32'h8, 32'd3);

    // Graceful stop requested a few bits into the right channel.
    n = 0;
    while (!ws && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) measure_rise(n);
    wb_write(32'h0, 32'h000F0100);
    check_output("ws_right_at_stop", {31'd0, ws}, 32'd1);
    wait_frames(4);
    check_output("stop_frame_complete", 32'(fs_last - fs_prev), 32'd128);
    repeat (2) @(negedge clk);
    check_output("idle_sck_ws_low", {30'd0, sck, ws}, 32'd0);
    wb_check("status_stopped", 32'h4, 32'h2);
    repeat (300) @(negedge clk);
    check_output("no_frames_after_stop", 32'(fs_count), 32'd4);

    // Shadowing: mid-frame divider/length change applies from the next frame.
    wb_write(32'h0, 32'h000F0101);
    wait_frames(5);
    repeat (20) @(negedge clk);
    wb_write(32'h0, 32'h001F0301);
    wb_check("ctrl_readback", 32'h0, 32'h001F0301);
    wait_frames(6);
    check_output("shadow_keeps_128", 32'(fs_last - fs_prev), 32'd128);
    wait_frames(7);
    check_output("shadow_new_512", 32'(fs_last - fs_prev), 32'd512);

    // WLEN clamp to 7 -> 16 SCK periods of 4 clocks.
    wb_write(32'h0, 32'h00020101);
    wb_check("wlen_clamp_readback", 32'h0, 32'h00070101);
    wait_frames(8);
    check_output("frame_before_clamp", 32'(fs_last - fs_prev), 32'd512);
    wait_frames(9);
    check_output("clamped_frame_64", 32'(fs_last - fs_prev), 32'd64);

    // Interrupt
    wb_write(32'h4, 32'h2);
    wb_check("status_irq_cleared", 32'h4, 32'h1);
    wb_write(32'h0, 32'h00070103);
    check_output("irq_low_before_boundary", {31'd0, irq}, 32'd0);
    wait_frames(10);
    check_output("irq_high_at_boundary", {31'd0, irq}, 32'd1);
    check_output("irq_rise_time", 32'(irq_rise_t), 32'(fs_last));
    wb_write(32'h4, 32'h2);
    check_output("irq_w1c", {31'd0, irq}, 32'd0);
    repeat (62) @(negedge clk);
    wb_write(32'h4, 32'h2);
    wb_check("w1c_vs_boundary", 32'h4, 32'h3);

    wait_frames(12);
    repeat (63) @(negedge clk);
    wb_write(32'h8, 32'h0);
    wb_check("fcnt_clear_vs_boundary", 32'h8, 32'd1);
    wb_write(32'h8, 32'hFFFF_FFFF);
    wb_check("fcnt_clear", 32'h8, 32'd0);

    // Asynchronous reset while running
    repeat (10) @(negedge clk);
    check_output("irq_before_reset", {31'd0, irq}, 32'd1);
    #2 rst = 1'b1;
    #1 check_output("async_reset_outputs", {28'd0, sck, ws, irq, frame_start}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_check("ctrl_after_reset", 32'h0, 32'h000F0100);
    wb_check("status_after_reset", 32'h4, 32'h0);
    wb_check("fcnt_after_reset", 32'h8, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/i2s_clk_ctrl.md
Name: i2s_clk_ctrl

Overview:
Wishbone-configurable I2S bus-master timing controller for the i2s_to_wb transmit path. It derives SCK and WS from the main I2S clock, feeding the i2s_sck_i/i2s_ws_i inputs of i2s_to_wb_top, so the DUT no longer depends on the bench BFM for bit clocks. It also provides frame-boundary sequencing, clean start/stop, a frame counter and a frame interrupt.

Parameters:
DIV_RST, 8'd1, reset value of CTRL.DIV; SCK half-period is DIV+1 clocks.
WLEN_RST, 5'd15, reset value of CTRL.WLEN; there are WLEN+1 bits per channel.

Ports:
i2s_clk_i  in  1  main clock, ~18.4 MHz; all logic is on the rising edge.
i2s_rst_i  in  1  asynchronous, active-high reset.
wbs_data_i  in  32  Wishbone write data.
wbs_data_o  out  32  Wishbone read data.
wbs_addr_i  in  32  byte address; only [3:2] is decoded.
wbs_sel_i  in  4  byte selects; ignored, full-word access only.
wbs_we_i  in  1  write enable.
wbs_cyc_i  in  1  cycle.
wbs_stb_i  in  1  strobe.
wbs_ack_o  out  1  acknowledge.
wbs_err_o  out  1  tied 0.
wbs_rty_o  out  1  tied 0.
i2s_sck_o  out  1  I2S bit clock.
i2s_ws_o  out  1  I2S word select; 0 = left, 1 = right.
frame_start_o  out  1  one-clock pulse at each frame boundary.
irq_o  out  1  level interrupt: STATUS.IRQ AND CTRL.IRQ_EN.

Behaviour:
- Reset (async) state: all outputs 0; CTRL = {WLEN_RST, DIV_RST, IRQ_EN=0, EN=0}; counters 0; state IDLE.
- Register map:
  - 0x0 CTRL (RW): [0] EN, [1] IRQ_EN, [15:8] DIV, [20:16] WLEN. Written WLEN < 7 is stored as 7.
  - 0x4 STATUS: [0] RUNNING (RO), [1] IRQ (write-1-to-clear).
  - 0x8 FRAME_CNT (RO): any write clears it.
  - 0xC: reads 0, writes ignored.
  - Unused bits read 0.
- Wishbone handshake:
  - ack asserts for one clock in the cycle after cyc&stb&~ack (one wait state). It deasserts for at least one cycle between back-to-back accesses.
  - Write takes effect on the ack cycle. Read data is registered and valid with ack.
- Shadow registers: DIV and WLEN are copied to working registers only on IDLE->RUN and at each frame boundary. Mid-frame CTRL writes never disturb timing.
- State machine:
  - IDLE: sck=0, ws=0, div_cnt=0, bit_cnt=0, RUNNING=0. EN=1 loads the shadows and moves to RUN on the next clock.
  - RUN: div_cnt counts 0..DIV. At terminal count, div_cnt clears and sck toggles.
  - RUN, on each sck falling toggle: if bit_cnt==WLEN, then bit_cnt<=0 and ws toggles; otherwise bit_cnt increments. WS therefore changes on the SCK falling edge, one SCK before the MSB of the next word.
  - Frame boundary = ws toggling 1->0. In that same clock: frame_start_o pulses, FRAME_CNT increments (wraps 0xFFFFFFFF->0), STATUS.IRQ sets, and the shadows reload.
  - STOP: EN=0 while in RUN moves to STOP. Timing continues until the next frame boundary, then IDLE with sck=0, ws=0.
  - STOP with EN=1 again before the boundary: return to RUN with no glitch.
  - No partial frames are ever emitted.
- Timing: first sck rise is DIV+1 clocks after entering RUN. SCK period = 2(DIV+1) clocks. Frame = 2(WLEN+1) SCK periods.
- Simultaneous events:
  - IRQ set and W1C in the same cycle: set wins.
  - FRAME_CNT write-clear and increment in the same cycle: result is 1.
  - CTRL write and frame boundary in the same cycle: the shadows take the newly written values.
- Reset mid-frame: outputs drop to 0 asynchronously; no completion pulse is generated.

Test Plan:
- Reset defaults: assert reset mid-RUN -> sck/ws/irq_o/frame_start_o = 0 immediately; reads return CTRL=0x000F0100, STATUS=0, FRAME_CNT=0.
- Basic timing: write CTRL=0x000F0101 -> sck period = 4 clocks.
  - First rise 2 clocks after RUN.
  - ws high after 16 SCK falls.
  - frame_start_o every 128 clocks.
  - FRAME_CNT=3 after 3 frames.
- Graceful stop: clear EN at bit 5 of the right channel -> frame completes, then IDLE; sck stays 0 and RUNNING=0 two clocks after the final frame_start_o.
- Shadowing: while running, write DIV=3, WLEN=31 mid-frame -> current frame keeps the 128-clock period; next frame is 2*32*8 = 512 clocks.
- WLEN clamp: writing WLEN=2 reads back 7 -> frame = 16 SCK periods.
- Interrupt:
  - IRQ_EN=1 -> irq_o rises in the boundary clock.
  - W1C clears it.
  - W1C coincident with a boundary leaves IRQ=1.
  - Writing FRAME_CNT coincident with a boundary reads 1.
